elpis_uart_tx: RTL
==================

# elpis_uart_tx

Byte-serial UART transmitter (8N1) that gives the Elpis core its output path. The core's output instruction pushes bytes into a small FIFO. The block serialises them LSB-first onto one user-project IO pin (mprj_io[6] at chip level), where the bench UART receiver or an external host decodes them. It is the transmit counterpart of the core's input/read path and sits beside the core inside the user project wrapper.

## Interface
Parameters:
- CLK_DIV, 4167, clock cycles per bit (40 MHz / 9600 baud); legal range 2..65535
- FIFO_DEPTH, 4, byte FIFO entries; power of two, at least 2

Ports:
- wb_clk_i  input  1  single clock, all logic rising-edge
- wb_rst_i  input  1  synchronous, active-high reset
- wr_valid  input  1  core presents a byte
- wr_data  input  8  byte to transmit
- wr_ready  output  1  FIFO can accept (not full)
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress or FIFO non-empty
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes queued, excluding the frame being shifted

## Operation
- Reset state, asserted on the first rising edge with wb_rst_i=1:
  - tx=1, busy=0, wr_ready=1, fifo_count=0
  - FIFO pointers cleared; FSM in IDLE; bit and baud counters cleared
- Write: the byte is accepted on a rising edge where wr_valid=1 and wr_ready=1.
  - wr_ready = (fifo_count != FIFO_DEPTH), derived from registered state only.
  - Writes while full are ignored. The core must hold wr_valid until wr_ready.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head into an 8-bit shift register and go to START.
  - START: tx=0 for CLK_DIV cycles, then DATA with bit index 0.
  - DATA: tx=shift[0] for CLK_DIV cycles per bit, shifting right after each bit. After bit index 7, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. Then:
    - if the FIFO is non-empty, pop and go directly to START, with no idle cycles between frames;
    - otherwise go to IDLE.
- Baud counter:
  - 16-bit, counts 0..CLK_DIV-1.
  - Reloads to 0 at every state/bit boundary.
  - tx changes only at boundaries.
- tx is driven straight from a register, so it is glitch-free.
- fifo_count:
  - +1 on an accepted write;
  - -1 on a pop;
  - unchanged when both happen on the same edge.
- busy = (state != IDLE) || (fifo_count != 0).
- Reset mid-frame: on the reset edge tx returns to 1, the frame is abandoned and the FIFO is flushed. There is no partial stop bit.

## Timing
- Write accepted at edge N into an idle block with an empty FIFO:
  - fifo_count=1 after edge N;
  - pop and tx=0 after edge N+1;
  - fifo_count returns to 0 after edge N+1.
- Frame length: exactly 10*CLK_DIV cycles.
  - Start bit begins at edge N+1.
  - Data bit k occupies cycles [N+1+(k+1)*CLK_DIV, N+1+(k+2)*CLK_DIV).
  - Stop bit ends at N+1+10*CLK_DIV.
- Back-to-back bytes: the next start bit begins on the edge where the previous stop bit ends. Throughput is 1 byte per 10*CLK_DIV cycles.
- Full FIFO with a pop on the same edge: wr_ready is still 0 in that cycle. Space appears on the next cycle.
- Write and pop on the same edge with FIFO count 1: both happen and the count stays 1. FIFO ordering is strict: first in, first out.
- Write during IDLE into an empty FIFO is never bypassed; it always passes through the FIFO, which gives the 1-cycle latency above.

## Test plan
- Reset: hold wb_rst_i for 3 cycles -> tx=1, busy=0, wr_ready=1, fifo_count=0 on every cycle while reset is high.
- Single byte, CLK_DIV=4: write 0xA5 -> starting 1 cycle after acceptance, tx holds each bit for 4 cycles in the order 0, 1,0,1,0,0,1,0,1, 1 (40 cycles total); then busy drops to 0.
- Back-to-back, CLK_DIV=4: write 0x00 then 0xFF on consecutive cycles -> two contiguous 40-cycle frames with no idle gap; a bench UART model decodes 0x00 then 0xFF.
- Full and overflow, FIFO_DEPTH=4, CLK_DIV=4: write 6 bytes 0x31..0x36 holding wr_valid:
  - 0x31 pops immediately and 0x32..0x35 fill the FIFO;
  - wr_ready=0 until the first frame ends;
  - 0x36 is then accepted;
  - the 6 bytes are decoded in order.
- Reset mid-frame: assert wb_rst_i during data bit 3 of 0x0F with 2 bytes queued -> tx=1 after the reset edge, fifo_count=0, and no further frames appear after release.
- Chip level: the core writes ASCII "OK" through its output instruction -> tbuart on mprj_io[6] at 9600 baud prints "OK"; the register-check wait then finishes the test.

Source files
------------

// File: rtl/elpis_uart_tx.sv
// -----------------------------------------------------------------------------
// elpis_uart_tx
//
// Byte-serial 8N1 UART transmitter. It is the output path of the Elpis core.
// The core pushes bytes into a small FIFO. The FSM pops them one at a time and
// shifts each one out LSB-first on `tx`:
//   1 start bit (0), 8 data bits, 1 stop bit (1), each CLK_DIV cycles long.
// When the FIFO still holds data at the end of a stop bit, the next start bit
// begins on that same edge, so consecutive frames have no idle gap.
//
// Write handshake (valid/ready):
//   A byte is transferred on every rising edge where wr_valid and wr_ready are
//   both high. wr_ready depends only on registered state; it never depends on
//   wr_valid in the same cycle. The producer holds wr_valid and wr_data stable
//   until wr_ready is seen high. A write while full is not a transfer and is
//   ignored. A byte written into an idle, empty block still passes through the
//   FIFO, so the start bit begins one cycle after acceptance.
//
// Parameters:
//   CLK_DIV     clock cycles per bit, 2..65535 (default: 40 MHz / 9600 baud)
//   FIFO_DEPTH  byte FIFO entries, power of two, >= 2
//
// Ports:
//   wb_clk_i     in   single clock, rising edge
//   wb_rst_i     in   synchronous active-high reset
//   wr_valid     in   core presents a byte
//   wr_data      in   [7:0] byte to transmit
//   wr_ready     out  FIFO not full
//   tx           out  serial line, idle high, driven straight from a flop
//   busy         out  frame in progress or FIFO non-empty
//   fifo_count   out  bytes queued, excluding the frame being shifted
//   dbg_state_o  out  current FSM state (state_e encoding)
// -----------------------------------------------------------------------------
module elpis_uart_tx #(
  parameter int CLK_DIV    = 4167,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        wr_valid,
  input  logic [7:0]                  wr_data,
  output logic                        wr_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [1:0]                  dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_LAST  = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Shared decode
  // ---------------------------------------------------------------------------
  logic       push;
  logic       pop;
  logic       fifo_nonempty;
  logic       baud_done;
  logic [7:0] head;

  assign wr_ready      = (count_q != FULL_COUNT);
  assign push          = wr_valid && wr_ready;
  assign fifo_nonempty = (count_q != '0);
  assign baud_done     = (baud_q == BAUD_LAST);
  assign head          = mem[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // FSM next-state / outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Hold the baud counter at zero so that every frame starts with a
        // full-length start bit.
        baud_d = '0;
        tx_d   = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            // The next bit is shift_q[1]. tx_d is loaded from it directly so
            // that tx stays a flop output and changes only on this edge.
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end

      S_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (fifo_nonempty) begin
            // Chain straight into the next start bit: no idle cycle.
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        baud_d  = '0;
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO pointer / occupancy next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // A push and a pop on the same edge leave the occupancy unchanged.
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // The FIFO storage has no reset. An entry is only ever read after it has
  // been written, because the pointers and the count are reset.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tx          = tx_q;
  assign busy        = (state_q != S_IDLE) || fifo_nonempty;
  assign fifo_count  = count_q;
  assign dbg_state_o = state_q;

endmodule
